// File: rtl/pwm_gate_driver.sv
// Complementary PWM gate driver with dead time, shadow-registered duty, soft-start and latched trip.
// Optional build macro TRIP_CNT_EN enables the saturating RUN->TRIP event counter on trip_count.
module pwm_gate_driver #(
  parameter int DEAD_TIME  = 4,
  parameter int SS_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  input  logic       fault_in,
  input  logic       fault_clr,
  output logic       gate_hi,
  output logic       gate_lo,
  output logic       fault,
  output logic       period_strobe,
  output logic [7:0] trip_count
);

  localparam logic [3:0]  DT_LAST = 4'(DEAD_TIME - 1);
  localparam logic [15:0] SS_LAST = 16'(SS_PERIODS - 1);

  typedef enum logic [1:0] {ST_LO, ST_DT_H, ST_HI, ST_DT_L} state_t;

  logic [7:0]  r_cnt;
  logic [7:0]  r_activeDuty;
  logic [7:0]  r_pending;
  logic        r_pendFull;
  logic [7:0]  r_ssLimit;
  logic [15:0] r_ssDiv;
  logic        r_fault;
  logic        r_periodStrobe;
  state_t      r_state;
  logic [3:0]  r_dtCnt;
  logic        r_gateHi;
  logic        r_gateLo;

  logic        w_wrap;
  logic        w_xfer;
  logic        w_tripSet;
  logic        w_tripClr;
  logic [7:0]  w_effDuty;
  logic        w_raw;
  state_t      w_stNext;
  logic [3:0]  w_dtNext;

  assign w_wrap    = ena && (r_cnt == 8'hFF);
  assign w_xfer    = duty_valid && !r_pendFull;
  assign w_tripSet = !r_fault && fault_in;
  assign w_tripClr = r_fault && fault_clr && !fault_in;
  assign w_effDuty = (r_activeDuty < r_ssLimit) ? r_activeDuty : r_ssLimit;
  assign w_raw     = (r_cnt < w_effDuty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= 8'd0;
      r_periodStrobe <= 1'b0;
    end else begin
      if (ena) begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_periodStrobe <= w_wrap;
    end
  end

  // Shadow register: a new command only reaches active_duty at the period wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_activeDuty <= 8'd0;
      r_pending    <= 8'd0;
      r_pendFull   <= 1'b0;
    end else if (w_wrap && r_pendFull) begin
      r_activeDuty <= r_pending;
      r_pendFull   <= 1'b0;
    end else if (w_xfer) begin
      r_pending    <= duty_in;
      r_pendFull   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_tripSet) begin
      r_fault <= 1'b1;
    end else if (w_tripClr) begin
      r_fault <= 1'b0;
    end
  end

  // Soft-start is held at zero for the whole trip so it restarts cleanly on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssLimit <= 8'd0;
      r_ssDiv   <= 16'd0;
    end else if (w_tripSet || r_fault) begin
      r_ssLimit <= 8'd0;
      r_ssDiv   <= 16'd0;
    end else if (w_wrap) begin
      if (r_ssDiv == SS_LAST) begin
        r_ssDiv <= 16'd0;
        if (r_ssLimit != 8'hFF) begin
          r_ssLimit <= r_ssLimit + 8'd1;
        end
      end else begin
        r_ssDiv <= r_ssDiv + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_DT_L;
      r_dtCnt  <= 4'd0;
      r_gateHi <= 1'b0;
      r_gateLo <= 1'b0;
    end else begin
      r_state  <= w_stNext;
      r_dtCnt  <= w_dtNext;
      r_gateHi <= (w_stNext == ST_HI);
      r_gateLo <= (w_stNext == ST_LO);
    end
  end

  // Gates come from the next state so a trip or disable clears them on the very next edge.
  always_comb begin
    w_stNext = r_state;
    w_dtNext = r_dtCnt;
    if (!ena || w_tripSet || r_fault) begin
      w_stNext = ST_DT_L;
      w_dtNext = 4'd0;
    end else begin
      case (r_state)
        ST_LO: begin
          if (w_raw) begin
            w_stNext = ST_DT_H;
            w_dtNext = 4'd0;
          end
        end
        ST_DT_H: begin
          if (!w_raw) begin
            w_stNext = ST_LO;
            w_dtNext = 4'd0;
          end else if (r_dtCnt == DT_LAST) begin
            w_stNext = ST_HI;
            w_dtNext = 4'd0;
          end else begin
            w_dtNext = r_dtCnt + 4'd1;
          end
        end
        ST_HI: begin
          if (!w_raw) begin
            w_stNext = ST_DT_L;
            w_dtNext = 4'd0;
          end
        end
        ST_DT_L: begin
          if (w_raw) begin
            w_stNext = ST_HI;
            w_dtNext = 4'd0;
          end else if (r_dtCnt == DT_LAST) begin
            w_stNext = ST_LO;
            w_dtNext = 4'd0;
          end else begin
            w_dtNext = r_dtCnt + 4'd1;
          end
        end
        default: begin
          w_stNext = ST_DT_L;
          w_dtNext = 4'd0;
        end
      endcase
    end
  end

`ifdef TRIP_CNT_EN
  logic [7:0] r_tripCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tripCount <= 8'd0;
    end else if (w_tripSet && (r_tripCount != 8'hFF)) begin
      r_tripCount <= r_tripCount + 8'd1;
    end
  end

  assign trip_count = r_tripCount;
`else
  assign trip_count = 8'd0;
`endif

  assign duty_ready    = !r_pendFull;
  assign gate_hi       = r_gateHi;
  assign gate_lo       = r_gateLo;
  assign fault         = r_fault;
  assign period_strobe = r_periodStrobe;

endmodule

// File: tb/tb_pwm_gate_driver.sv
// Self-checking bench for pwm_gate_driver: per-period gate high/low-off counts against hand-computed values.
// Runs with SS_PERIODS=1 so the soft-start ramp completes in a reasonable number of periods.
module tb_pwm_gate_driver;

  typedef struct {
    logic [7:0] duty;
    bit         sendSecond;
    logic [7:0] second;
    int         expHi;
    int         expLoOff;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       fault_in;
  logic       fault_clr;
  logic       gate_hi;
  logic       gate_lo;
  logic       fault;
  logic       period_strobe;
  logic [7:0] trip_count;

  int testsRun     = 0;
  int testsFailed  = 0;
  int hiAcc        = 0;
  int loOffAcc     = 0;
  int lastHi       = 0;
  int lastLoOff    = 0;
  int overlapCount = 0;

  vec_t vecs [8];

  pwm_gate_driver #(.DEAD_TIME(4), .SS_PERIODS(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .duty_in       (duty_in),
    .duty_valid    (duty_valid),
    .duty_ready    (duty_ready),
    .fault_in      (fault_in),
    .fault_clr     (fault_clr),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .fault         (fault),
    .period_strobe (period_strobe),
    .trip_count    (trip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-period accumulation of gate_hi-high and gate_lo-low cycles, latched at each strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      hiAcc    <= 0;
      loOffAcc <= 0;
    end else if (period_strobe) begin
      lastHi    <= hiAcc;
      lastLoOff <= loOffAcc;
      hiAcc     <= (gate_hi ? 1 : 0);
      loOffAcc  <= (gate_lo ? 0 : 1);
    end else begin
      hiAcc    <= hiAcc + (gate_hi ? 1 : 0);
      loOffAcc <= loOffAcc + (gate_lo ? 0 : 1);
    end
    if (gate_hi && gate_lo) overlapCount <= overlapCount + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run exceeded time limit, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit two, input logic [7:0] d2);
    @(negedge clk);
    duty_in    = d;
    duty_valid = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_xfer", int'(duty_ready), 0);
    if (two) begin
      duty_in = d2;
      @(negedge clk);
      checkOutput("ready_while_full", int'(duty_ready), 0);
    end
    duty_valid = 1'b0;
  endtask

  task automatic waitStrobe(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!period_strobe && cycles < 400);
    if (!period_strobe) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL strobe_timeout: got no period_strobe in %0d cycles, expected one", cycles);
    end
    #1;
  endtask

  initial begin
    int cyc;
    int eff;
    int expHi;
    int expLo;
    int prevHi;
    int prevLo;
    int badGate;
    int expTrips;

    vecs[0] = '{8'd200, 1'b0, 8'd0,  196, 204};
    vecs[1] = '{8'd50,  1'b0, 8'd0,  46,  54};
    vecs[2] = '{8'd3,   1'b0, 8'd0,  0,   3};
    vecs[3] = '{8'd4,   1'b0, 8'd0,  0,   4};
    vecs[4] = '{8'd5,   1'b0, 8'd0,  1,   9};
    vecs[5] = '{8'd90,  1'b1, 8'd20, 86,  94};
    vecs[6] = '{8'd0,   1'b0, 8'd0,  0,   0};
    vecs[7] = '{8'd1,   1'b0, 8'd0,  0,   1};

`ifdef TRIP_CNT_EN
    expTrips = 1;
`else
    expTrips = 0;
`endif

    rst_n      = 1'b0;
    ena        = 1'b0;
    duty_in    = 8'd0;
    duty_valid = 1'b0;
    fault_in   = 1'b0;
    fault_clr  = 1'b0;
    #22;
    checkOutput("rst_gate_hi", int'(gate_hi), 0);
    checkOutput("rst_gate_lo", int'(gate_lo), 0);
    checkOutput("rst_fault", int'(fault), 0);
    checkOutput("rst_strobe", int'(period_strobe), 0);
    checkOutput("rst_ready", int'(duty_ready), 1);
    checkOutput("rst_trip_count", int'(trip_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Soft-start ramp: period k runs at min(128, k) with one limit step per wrap.
    repeat (10) @(negedge clk);
    applyStimulus(8'd128, 1'b0, 8'd0);
    waitStrobe(cyc);
    checkOutput("ready_after_wrap", int'(duty_ready), 1);
    checkOutput("p0_gate_hi", lastHi, 0);
    for (int k = 1; k < 200; k++) begin
      waitStrobe(cyc);
      if (k <= 130) begin
        eff   = (k < 128) ? k : 128;
        expHi = (eff > 4) ? eff - 4 : 0;
        expLo = (eff > 4) ? eff + 4 : eff;
        checkOutput($sformatf("ramp%0d_hi", k), lastHi, expHi);
        checkOutput($sformatf("ramp%0d_lo_off", k), lastLoOff, expLo);
        checkOutput($sformatf("ramp%0d_period", k), cyc, 256);
      end
    end

    // Mid-period updates: the running period keeps the old duty, the next one takes the new.
    prevHi = 124;
    prevLo = 132;
    for (int i = 0; i < 8; i++) begin
      repeat (100) @(negedge clk);
      applyStimulus(vecs[i].duty, vecs[i].sendSecond, vecs[i].second);
      waitStrobe(cyc);
      checkOutput($sformatf("vec%0d_old_hi", i), lastHi, prevHi);
      checkOutput($sformatf("vec%0d_old_lo_off", i), lastLoOff, prevLo);
      checkOutput($sformatf("vec%0d_ready", i), int'(duty_ready), 1);
      waitStrobe(cyc);
      checkOutput($sformatf("vec%0d_new_hi", i), lastHi, vecs[i].expHi);
      checkOutput($sformatf("vec%0d_new_lo_off", i), lastLoOff, vecs[i].expLoOff);
      prevHi = vecs[i].expHi;
      prevLo = vecs[i].expLoOff;
    end

    // Disable for 100 cycles mid-period with duty 1 active.
    cyc = 0;
    repeat (50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("lo_before_idle", int'(gate_lo), 1);
    ena     = 1'b0;
    badGate = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      cyc++;
      if (gate_hi || gate_lo || period_strobe) badGate++;
    end
    checkOutput("idle_gates_off", badGate, 0);
    ena = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      cyc++;
      checkOutput($sformatf("lo_resume_%0d", j), int'(gate_lo), (j == 4) ? 1 : 0);
    end
    do begin
      @(negedge clk);
      cyc++;
    end while (!period_strobe && cyc < 500);
    #1;
    checkOutput("frozen_period_len", cyc, 356);

    // Trip during HI, blocked clear, then a real clear with soft-start restart.
    applyStimulus(8'd100, 1'b0, 8'd0);
    waitStrobe(cyc);
    repeat (50) @(negedge clk);
    checkOutput("hi_before_trip", int'(gate_hi), 1);
    fault_in = 1'b1;
    @(negedge clk);
    checkOutput("trip_fault", int'(fault), 1);
    checkOutput("trip_gate_hi", int'(gate_hi), 0);
    checkOutput("trip_gate_lo", int'(gate_lo), 0);
    fault_clr = 1'b1;
    @(negedge clk);
    checkOutput("clr_with_fault_in", int'(fault), 1);
    fault_clr = 1'b0;
    fault_in  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("trip_latched", int'(fault), 1);
    checkOutput("trip_lo_off", int'(gate_lo), 0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checkOutput("clr_fault", int'(fault), 0);
    checkOutput("trip_count", int'(trip_count), expTrips);
    waitStrobe(cyc);
    waitStrobe(cyc);
    checkOutput("ss_restart1_hi", lastHi, 0);
    checkOutput("ss_restart1_lo_off", lastLoOff, 1);
    waitStrobe(cyc);
    checkOutput("ss_restart2_lo_off", lastLoOff, 2);

    // Asynchronous reset mid-period with a command still pending.
    applyStimulus(8'd200, 1'b0, 8'd0);
    repeat (20) @(negedge clk);
    checkOutput("lo_before_reset", int'(gate_lo), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_gate_lo", int'(gate_lo), 0);
    checkOutput("async_rst_ready", int'(duty_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    waitStrobe(cyc);
    waitStrobe(cyc);
    checkOutput("pending_discarded", lastLoOff, 0);

    checkOutput("no_overlap", overlapCount, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pwm_gate_driver.md
Name: pwm_gate_driver

Overview:
- Downstream stage of the renewable-energy converter core. It consumes the 8-bit duty command that the converter produces from the input-voltage sample.
- It generates complementary high-side and low-side gate drives with programmable dead time.
- It also provides period-aligned duty updates through a shadow register, a soft-start ramp, and a latched fault trip.

Parameters:
- DEAD_TIME, 4, dead-time length in clk cycles (1..15).
- SS_PERIODS, 2, number of PWM periods per +1 step of the soft-start limit (≥1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when low, counters freeze and gates are forced off
- duty_in  input  8  duty command from the converter core
- duty_valid  input  1  duty_in is valid this cycle
- duty_ready  output  1  shadow register can accept a command
- fault_in  input  1  overcurrent/overvoltage comparator (already synchronous)
- fault_clr  input  1  single-cycle request to leave the trip state
- gate_hi  output  1  high-side switch drive
- gate_lo  output  1  low-side switch drive
- fault  output  1  trip latched
- period_strobe  output  1  one-cycle pulse on the cycle where cnt wraps 255→0
- trip_count  output  8  saturating trip counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, active_duty=0, pending empty, ss_limit=0, state=RUN.
  - Outputs: gate_hi=0, gate_lo=0, fault=0, period_strobe=0, duty_ready=1, trip_count=0.
- Counter: 8-bit cnt increments on each clk while ena=1 and wraps 255→0. The period is 256 cycles. period_strobe is registered and is high in the cycle after cnt==255 has been counted, i.e. while cnt==0.
- Handshake:
  - duty_ready = !pending_full.
  - A transfer occurs when duty_valid && duty_ready; pending takes duty_in.
  - duty_valid while not ready is ignored, and the command is not held.
- Period update: at the wrap (cnt==255 with ena=1), if pending_full then active_duty←pending and pending_full is cleared. Otherwise active_duty holds.
  - A transfer in the same wrap cycle with pending already empty goes into pending and takes effect at the next wrap.
- Soft-start:
  - ss_limit increments by 1 every SS_PERIODS wraps and saturates at 255.
  - eff_duty = min(active_duty, ss_limit).
- Raw PWM: raw = (cnt < eff_duty).
  - eff_duty=0 gives raw always 0.
  - eff_duty=255 gives raw=1 for 255 of 256 cycles.
- Dead time (FSM states LO, DT_H, HI, DT_L):
  - LO: gate_lo=1. If raw=1, go to DT_H with dt_cnt=0.
  - DT_H: both gates 0. If raw returns to 0, go to LO. If dt_cnt reaches DEAD_TIME-1, go to HI.
  - HI: gate_hi=1. If raw=0, go to DT_L.
  - DT_L: mirror of DT_H, ending in LO.
  - Gate outputs are registered. gate_hi and gate_lo are never both 1 in any cycle.
  - Pulses shorter than DEAD_TIME are swallowed.
- ena=0: cnt, ss_limit and active_duty hold; dead-time FSM is forced to DT_L with dt_cnt=0; both gates are 0. The handshake still operates.
- Trip:
  - fault_in=1 in RUN sets fault=1 on the next edge and forces both gates to 0 in that same registered update.
  - ss_limit←0, FSM←DT_L. cnt keeps running.
  - In TRIP, fault_clr=1 with fault_in=0 returns to RUN. Soft-start then restarts from 0.
  - fault_clr while fault_in=1 is ignored. fault_in and fault_clr asserted together: the trip wins.
- Reset mid-period: immediate gate-off. pending is discarded.

Optional Feature:
- Macro TRIP_CNT_EN.
- Defined: trip_count increments on each RUN→TRIP transition and saturates at 255. It is cleared only by rst_n.
- Undefined: trip_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, ena=1, send duty_in=128 once → duty_ready drops for one transfer and rises at the next wrap.
  - gate_hi stays 0 while ss_limit ramps; with SS_PERIODS=2, ss_limit reaches 128 after 256 periods.
  - Then the high time is 128-DEAD_TIME=124 cycles per 256.
- Steady duty 200 after soft-start; send 50 mid-period → the current period keeps 200; the next period begins at 50. period_strobe pulses once per 256 cycles.
- Send two commands back-to-back mid-period → the first is accepted; duty_ready=0 so the second is dropped. active_duty becomes the first value at the wrap.
- Duty 3 with DEAD_TIME=4 → gate_hi never asserts, gate_lo drops for 3 cycles plus return.
  - Check every cycle: !(gate_hi && gate_lo).
- Assert fault_in for 1 cycle during HI → both gates 0 on the next edge and fault=1. fault_clr with fault_in=1 has no effect.
  - fault_clr with fault_in=0 gives fault=0 and soft-start from 0. trip_count=1 if TRIP_CNT_EN is defined, else 0.
- Drop ena for 100 cycles mid-period → gates 0 and cnt frozen.
  - Re-enable → counting resumes from the frozen cnt, and gate_lo reasserts after DEAD_TIME cycles.
